alu_arbiter: RTL
================

# alu_arbiter

Shares the single ALU datapath (the result mux and its functional units) between two requesters, e.g. the main execute stage and the address/shift sequencer. It arbitrates round-robin, registers the winning operands and ALUControl code, captures the ALU result and NZCV flags one cycle later, and holds them until the owning requester accepts them. Each operation takes at least 3 cycles and only one is outstanding at a time.

## Interface
- N, 32, operand/result width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester operation request
- req_ready  out  2  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
- req0_a, req0_b  in  N  requester 0 operands
- req1_a, req1_b  in  N  requester 1 operands
- req0_ctrl, req1_ctrl  in  4  ALUControl code per requester
- alu_a, alu_b  out  N  operands to the ALU
- alu_ctrl  out  4  ALUControl to the ALU/result mux
- alu_y  in  N  ALU result (combinational from alu_a/b/ctrl)
- alu_flags  in  4  ALU NZCV (combinational)
- rsp_valid  out  2  one-hot result valid, owner only
- rsp_ready  in  2  per-requester result accept
- rsp_y  out  N  captured result
- rsp_flags  out  4  captured NZCV

## Operation
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - Grant is combinational. If only one req_valid is set, that requester wins.
  - If both are set, the requester other than `last` wins.
  - req_ready[g]=1 for the winner only; req_ready=0 when no request is pending.
  - On the handshake edge: latch a/b/ctrl into operand registers, owner<=g, last<=g, go to ISSUE.
- ISSUE: alu_a/alu_b/alu_ctrl are driven from the operand registers. On the edge, rsp_y<=alu_y and rsp_flags<=alu_flags, then go to HOLD.
- HOLD:
  - rsp_valid[owner]=1; the other bit is 0.
  - Leave for IDLE on rsp_ready[owner]. rsp_ready on the non-owner bit is ignored.
- alu_a/alu_b/alu_ctrl hold the last latched values in every state. They change only on a request handshake.
- Control codes pass through unmodified, including 1000–1111 (the ALU returns its default result). Ctrl 0000 and 0001 are both the adder path.
- req_ready is 0 in ISSUE and HOLD. Requests wait. A requester that drops req_valid before its grant simply loses the cycle; there is no penalty.
- No width growth: rsp_y is exactly N bits. Carry/overflow are reported only via rsp_flags.

## Timing
- Reset values: state=IDLE, last=1 (requester 0 wins the first tie), owner=0, operand registers=0 (so alu_ctrl=0000), rsp_y=0, rsp_flags=0, rsp_valid=0. req_ready=0 while reset is high.
- Latency:
  - Handshake at edge T.
  - alu_* valid during cycle T+1.
  - rsp_valid high from T+2 until the edge on which rsp_ready[owner] is sampled high.
- Throughput: at most one operation per 3 cycles. A new grant is possible in the cycle after the HOLD exit.
- rsp_y/rsp_flags stay stable throughout HOLD, including when the ALU inputs are changed externally.
- Simultaneous events:
  - rsp_ready asserted in the first HOLD cycle: 1-cycle HOLD.
  - req_valid during HOLD: ignored until IDLE.
- Reset mid-operation (ISSUE or HOLD): the operation is discarded and no rsp_valid is produced. Next cycle all outputs are at their reset values.

## Structure
- Shared package alu_pkg:
  - state enum {IDLE, ISSUE, HOLD}.
  - ALUControl localparams: ALU_ADD=0000, ALU_SUB=0001, ALU_AND=0010, ALU_ORR=0011, ALU_EOR=0100, ALU_LSL=0101, ALU_LSR=0110, ALU_ASR=0111.
  - 1-bit requester index type.
- One sub-module: rr_arbiter2. It is combinational and takes req[1:0] and last, and produces a one-hot grant. The FSM, registers and `last` update stay in alu_arbiter.

## Test plan
- Reset held for 2 cycles with both req_valid=1 → req_ready=00, rsp_valid=00, alu_ctrl=0000.
- Single request: req0 a=5, b=3, ctrl=0000, ALU model returns 8 / NZCV=0000; rsp_ready=1 → handshake at T, alu_a=5 at T+1, rsp_valid=01 with rsp_y=8 at T+2, IDLE at T+3.
- Tie sequence: both valid continuously, rsp_ready=11 → grants alternate req0, req1, req0; req_ready pattern 01, 10, 01 every 3 cycles.
- Backpressure: req1 ctrl=0100, a=F0F0F0F0, b=FFFF0000; rsp_ready=00 for 5 cycles → rsp_valid=10 and rsp_y=0F0FF0F0 held stable. rsp_ready=01 has no effect; rsp_ready=10 releases.
- Undefined code: ctrl=1010 → alu_ctrl=1010 is driven unchanged and rsp_y equals the model's default result.
- Reset asserted during HOLD → next cycle rsp_valid=00, state IDLE, last=1; with both requests pending after reset, req0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and ALUControl codes for the two-requester ALU arbiter.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_LSL = 4'b0101;
    localparam logic [3:0] ALU_LSR = 4'b0110;
    localparam logic [3:0] ALU_ASR = 4'b0111;

    typedef logic req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the requester that did not win last time.
import alu_pkg::*;

module rr_arbiter2 (
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == 1'b1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: grant, issue one cycle, then hold
// the captured result/flags until the owner accepts them.
//
//   state | meaning
//   IDLE  | waiting for a request; grant is combinational
//   ISSUE | operand registers drive the ALU; result captured on the edge
//   HOLD  | rsp_valid to the owner until its rsp_ready
import alu_pkg::*;

module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req0_ctrl,
    input  logic [3:0]   req1_ctrl,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_y,
    input  logic [3:0]   alu_flags,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [N-1:0] rsp_y,
    output logic [3:0]   rsp_flags
);

    state_e       state_q, state_d;
    req_idx_t     last_q, last_d;
    req_idx_t     owner_q, owner_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [3:0]   ctrl_q, ctrl_d;
    logic [N-1:0] y_q, y_d;
    logic [3:0]   flags_q, flags_d;
    logic [1:0]   gnt;
    req_idx_t     win;

    rr_arbiter2 u_rr_arbiter2 (
        .req  (req_valid),
        .last (last_q),
        .gnt  (gnt)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        y_d       = y_q;
        flags_d   = flags_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        win       = gnt[1];

        case (state_q)
            IDLE: begin
                if (!reset) begin
                    req_ready = gnt;
                end
                // gnt is a subset of req_valid, so any grant is a handshake
                if (gnt != 2'b00) begin
                    owner_d = win;
                    last_d  = win;
                    a_d     = win ? req1_a    : req0_a;
                    b_d     = win ? req1_b    : req0_b;
                    ctrl_d  = win ? req1_ctrl : req0_ctrl;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                y_d     = alu_y;
                flags_d = alu_flags;
                state_d = HOLD;
            end
            HOLD: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 4'b0000;
            y_q     <= '0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_ctrl  = ctrl_q;
    assign rsp_y     = y_q;
    assign rsp_flags = flags_q;

endmodule
